// File: rtl/control_fsm.sv
// control_fsm: multicycle RISC-V main control; sequences FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
// Latency: BRANCH 3, R/I-ALU 4, STORE 4, LOAD 5 cycles; each cycle of imem/dmem not-ready adds one.
// Backpressure: imem_req/dmem_req stay high and stable until the matching ready; ready outside a request is ignored.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT (otherwise they retire as NOPs).
module control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [3:0]       alu_cmd,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_R = 4'b0000;
  localparam logic [3:0] ALU_I = 4'b0001;
  localparam logic [3:0] ALU_S = 4'b0010;
  localparam logic [3:0] ALU_B = 4'b0011;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [6:0] op_q;
  logic       retire;
  logic       op_legal;

  assign op_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                    (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // Next state, strobes and retire pulse from the current state and latched opcode.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_cmd    = ALU_I;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R: begin
            alu_cmd = ALU_R;
            state_d = S_WB;
          end
          OP_I: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_LOAD: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_STORE: begin
            alu_cmd = ALU_S;
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            alu_cmd   = ALU_B;
            pc_branch = zero;
            state_d   = S_FETCH;
            retire    = 1'b1;
          end
          // Illegal opcodes never reach EXEC; fall back to a clean fetch.
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; async reset drops any outstanding request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Opcode is captured once in DECODE so later input changes cannot disturb the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    op_q <= 7'd0;
    else if (state_q == S_DECODE)  op_q <= opcode;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 illegal_q <= 1'b0;
    else if (state_q == S_DECODE && !op_legal)  illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm built with CNT_W=4 so the counter wrap is reachable.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_control_fsm;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // Strobe vector: imem_req dmem_req dmem_we ir_write pc_write pc_branch reg_write mem_to_reg alu_src
  localparam logic [8:0] ST_NONE  = 9'b000000000;
  localparam logic [8:0] ST_FREQ  = 9'b100000000;
  localparam logic [8:0] ST_FETCH = 9'b100110000;
  localparam logic [8:0] ST_SRC   = 9'b000000001;
  localparam logic [8:0] ST_BR    = 9'b000001000;
  localparam logic [8:0] ST_MRD   = 9'b010000000;
  localparam logic [8:0] ST_MWR   = 9'b011000000;
  localparam logic [8:0] ST_WB    = 9'b000000100;
  localparam logic [8:0] ST_WBLD  = 9'b000000110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_branch;
  logic       reg_write, mem_to_reg, alu_src, illegal;
  logic [3:0] alu_cmd;
  logic [3:0] instret;
  logic [8:0] strb;

  int errors = 0;
  int checks = 0;

  assign strb = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_branch, reg_write, mem_to_reg, alu_src};

  control_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .alu_cmd(alu_cmd), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (strb !== ST_NONE) begin errors++; $display("FAIL rst_strb: got %b want %b", strb, ST_NONE); end
    checks++; if (alu_cmd !== 4'b0001) begin errors++; $display("FAIL rst_alu_cmd: got %b want 0001", alu_cmd); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL rst_instret: got %0d want 0", instret); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", illegal); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (strb !== ST_NONE) begin errors++; $display("FAIL idle_strb: got %b want %b", strb, ST_NONE); end
  endtask

  task automatic test_r_type();
    imem_ready = 1'b1; opcode = OP_R;
    tick();
    checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL r_fetch: got %b want %b", strb, ST_FETCH); end
    tick();
    checks++; if (strb !== ST_NONE || alu_cmd !== 4'b0001) begin errors++; $display("FAIL r_decode: got %b/%b want %b/0001", strb, alu_cmd, ST_NONE); end
    tick();
    opcode = OP_BAD;  // must be ignored after DECODE
    #1;
    checks++; if (strb !== ST_NONE || alu_cmd !== 4'b0000) begin errors++; $display("FAIL r_exec: got %b/%b want %b/0000", strb, alu_cmd, ST_NONE); end
    tick();
    checks++; if (strb !== ST_WB || instret !== 4'd0) begin errors++; $display("FAIL r_wb: got %b/%0d want %b/0", strb, instret, ST_WB); end
    tick();
    checks++; if (strb !== ST_FETCH || instret !== 4'd1) begin errors++; $display("FAIL r_retire: got %b/%0d want %b/1", strb, instret, ST_FETCH); end
  endtask

  task automatic test_load_wait();
    opcode = OP_LOAD; dmem_ready = 1'b0;
    tick();
    tick();
    checks++; if (strb !== ST_SRC || alu_cmd !== 4'b0001) begin errors++; $display("FAIL ld_exec: got %b/%b want %b/0001", strb, alu_cmd, ST_SRC); end
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      if (i == 2) begin dmem_ready = 1'b1; #1; end
      checks++; if (strb !== ST_MRD || alu_cmd !== 4'b0001) begin errors++; $display("FAIL ld_mem%0d: got %b want %b", i, strb, ST_MRD); end
    end
    tick();
    dmem_ready = 1'b0;
    checks++; if (strb !== ST_WBLD) begin errors++; $display("FAIL ld_wb: got %b want %b", strb, ST_WBLD); end
    tick();
    checks++; if (strb !== ST_FETCH || instret !== 4'd2) begin errors++; $display("FAIL ld_retire: got %b/%0d want %b/2", strb, instret, ST_FETCH); end
  endtask

  task automatic test_branch();
    zero = 1'b1; opcode = OP_BRANCH;
    tick(); tick();
    checks++; if (strb !== ST_BR || alu_cmd !== 4'b0011) begin errors++; $display("FAIL br_taken: got %b/%b want %b/0011", strb, alu_cmd, ST_BR); end
    tick();
    checks++; if (strb !== ST_FETCH || instret !== 4'd3) begin errors++; $display("FAIL br_taken_retire: got %b/%0d want %b/3", strb, instret, ST_FETCH); end
    zero = 1'b0;
    tick(); tick();
    checks++; if (strb !== ST_NONE || alu_cmd !== 4'b0011) begin errors++; $display("FAIL br_not_taken: got %b/%b want %b/0011", strb, alu_cmd, ST_NONE); end
    tick();
    checks++; if (strb !== ST_FETCH || instret !== 4'd4) begin errors++; $display("FAIL br_nt_retire: got %b/%0d want %b/4", strb, instret, ST_FETCH); end
  endtask

  task automatic test_i_alu_fetch_wait();
    imem_ready = 1'b0; opcode = OP_I;
    #1;
    checks++; if (strb !== ST_FREQ) begin errors++; $display("FAIL i_fetch_wait0: got %b want %b", strb, ST_FREQ); end
    tick();
    checks++; if (strb !== ST_FREQ) begin errors++; $display("FAIL i_fetch_wait1: got %b want %b", strb, ST_FREQ); end
    imem_ready = 1'b1;
    #1;
    checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL i_fetch_go: got %b want %b", strb, ST_FETCH); end
    tick(); tick();
    checks++; if (strb !== ST_SRC || alu_cmd !== 4'b0001) begin errors++; $display("FAIL i_exec: got %b/%b want %b/0001", strb, alu_cmd, ST_SRC); end
    tick();
    checks++; if (strb !== ST_WB) begin errors++; $display("FAIL i_wb: got %b want %b", strb, ST_WB); end
    tick();
    checks++; if (instret !== 4'd5) begin errors++; $display("FAIL i_retire: got %0d want 5", instret); end
  endtask

  task automatic test_store_reset();
    opcode = OP_STORE; dmem_ready = 1'b0;
    tick(); tick();
    checks++; if (strb !== ST_SRC || alu_cmd !== 4'b0010) begin errors++; $display("FAIL st_exec: got %b/%b want %b/0010", strb, alu_cmd, ST_SRC); end
    tick();
    checks++; if (strb !== ST_MWR) begin errors++; $display("FAIL st_mem: got %b want %b", strb, ST_MWR); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (strb !== ST_NONE || instret !== 4'd0) begin errors++; $display("FAIL st_async_rst: got %b/%0d want %b/0", strb, instret, ST_NONE); end
    tick();
    rst_n = 1'b1;
    checks++; if (strb !== ST_NONE) begin errors++; $display("FAIL st_idle: got %b want %b", strb, ST_NONE); end
    tick();
    checks++; if (strb !== ST_FETCH || instret !== 4'd0) begin errors++; $display("FAIL st_restart: got %b/%0d want %b/0", strb, instret, ST_FETCH); end
  endtask

  task automatic test_illegal();
    opcode = OP_BAD;
    tick();
    checks++; if (strb !== ST_NONE || illegal !== 1'b0) begin errors++; $display("FAIL ill_decode: got %b/%b want %b/0", strb, illegal, ST_NONE); end
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++; if (strb !== ST_NONE || illegal !== 1'b1) begin errors++; $display("FAIL ill_halt: got %b/%b want %b/1", strb, illegal, ST_NONE); end
    tick(); tick();
    checks++; if (strb !== ST_NONE || instret !== 4'd0 || illegal !== 1'b1) begin errors++; $display("FAIL ill_hold: got %b/%0d/%b want %b/0/1", strb, instret, illegal, ST_NONE); end
`else
    checks++; if (strb !== ST_FETCH || instret !== 4'd1 || illegal !== 1'b0) begin errors++; $display("FAIL ill_nop: got %b/%0d/%b want %b/1/0", strb, instret, illegal, ST_FETCH); end
`endif
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #1;
    checks++; if (instret !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL wrap_rst: got %0d/%b want 0/0", instret, illegal); end
    tick();
    rst_n = 1'b1;
    tick();
    opcode = OP_STORE; dmem_ready = 1'b1; imem_ready = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick(); tick(); tick(); tick();
      if (n == 15) begin
        checks++; if (instret !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d want 15", instret); end
      end
      if (n == 16) begin
        checks++; if (instret !== 4'd0 || strb !== ST_FETCH) begin errors++; $display("FAIL wrap_0: got %0d/%b want 0/%b", instret, strb, ST_FETCH); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_i_alu_fetch_wait();
    test_store_reset();
    test_illegal();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
